// File: rtl/mips_multicycle_main_control.sv
// mips_multicycle_main_control: multicycle MIPS main control FSM with memory handshake and retire counter.
// Define MAIN_CTRL_BNE_EN to add bne (opcode 000101) support.
module mips_multicycle_main_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             PCEn,
  output logic             Illegal,
  output logic [CNT_W-1:0] RetiredCnt
);
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
    BEQEX, ADDIEX, ADDIWB, JEX, BNEEX
  } state_t;
  state_t     state, state_nx;
  logic [5:0] opreg;
  logic       retire;
  always_comb begin
    {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
     ALUSrcB, ALUOp, PCSrc, PCEn, Illegal} = '0;
    state_nx = FETCH;
    retire = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCEn = MemReady;
        state_nx = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: state_nx = MEMADR;
          OP_R:         state_nx = RTYPEEX;
          OP_BEQ:       state_nx = BEQEX;
          OP_ADDI:      state_nx = ADDIEX;
          OP_J:         state_nx = JEX;
`ifdef MAIN_CTRL_BNE_EN
          OP_BNE:       state_nx = BNEEX;
`endif
          default:      Illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_nx = opreg == OP_LW ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD = 1'b1;
        MemRead = 1'b1;
        state_nx = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        retire = 1'b1;
      end
      MEMWR: begin
        IorD = 1'b1;
        MemWrite = 1'b1;
        state_nx = MemReady ? FETCH : MEMWR;
        retire = MemReady;
      end
      RTYPEEX: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b10;
        state_nx = RTYPEWB;
      end
      RTYPEWB: begin
        RegDst = 1'b1;
        RegWrite = 1'b1;
        retire = 1'b1;
      end
      BEQEX: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b01;
        PCSrc = 2'b01;
        PCEn = Zero;
        retire = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_nx = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        retire = 1'b1;
      end
      JEX: begin
        PCSrc = 2'b10;
        PCEn = 1'b1;
        retire = 1'b1;
      end
`ifdef MAIN_CTRL_BNE_EN
      BNEEX: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b01;
        PCSrc = 2'b01;
        PCEn = ~Zero;
        retire = 1'b1;
      end
`endif
      default: ;
    endcase
    // Reset kills every strobe combinationally, so a pending MemWrite drops without waiting for a clock
    if (!rst_n)
      {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
       ALUSrcB, ALUOp, PCSrc, PCEn, Illegal} = '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      opreg <= '0;
      RetiredCnt <= '0;
    end else begin
      state <= state_nx;
      if (state == DECODE) opreg <= Opcode;
      if (retire) RetiredCnt <= RetiredCnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mips_multicycle_main_control.sv
// tb_mips_multicycle_main_control: per-opcode micro-program reference model, directed table and random instruction stream.
module tb_mips_multicycle_main_control;
  localparam int CW = 4;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, BNE = 6'b000101, BAD = 6'b111111;
`ifdef MAIN_CTRL_BNE_EN
  localparam int BNE_CYC = 3;
`else
  localparam int BNE_CYC = 2;
`endif
  typedef enum {P_F, P_D, P_MA, P_MR, P_LWB, P_MW, P_RX, P_RWB, P_BX, P_NX, P_AX, P_AWB, P_JX, P_END} ph_t;
  typedef struct packed {
    logic iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic pcen, ill;
  } ctl_t;
  typedef struct {logic [5:0] op; int fw; int mw; int z; int cyc;} vec_t;
  logic clk = 0, rst_n = 0, Zero = 0, MemReady = 0;
  logic [5:0] Opcode = 0;
  logic IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, Illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [CW-1:0] RetiredCnt;
  int nvec = 0, nerr = 0, ret = 0;
  mips_multicycle_main_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .PCEn(PCEn), .Illegal(Illegal), .RetiredCnt(RetiredCnt)
  );
  always #5 clk = ~clk;
  function automatic logic legal(input logic [5:0] op);
`ifdef MAIN_CTRL_BNE_EN
    if (op == BNE) return 1'b1;
`endif
    return op inside {LW, SW, RT, BEQ, ADDI, JMP};
  endfunction
  function automatic ph_t nth(input logic [5:0] op, input int k);
    ph_t p [6];
    p = '{P_F, P_D, P_END, P_END, P_END, P_END};
    case (op)
      LW:   p = '{P_F, P_D, P_MA, P_MR, P_LWB, P_END};
      SW:   p = '{P_F, P_D, P_MA, P_MW, P_END, P_END};
      RT:   p = '{P_F, P_D, P_RX, P_RWB, P_END, P_END};
      BEQ:  p = '{P_F, P_D, P_BX, P_END, P_END, P_END};
      ADDI: p = '{P_F, P_D, P_AX, P_AWB, P_END, P_END};
      JMP:  p = '{P_F, P_D, P_JX, P_END, P_END, P_END};
`ifdef MAIN_CTRL_BNE_EN
      BNE:  p = '{P_F, P_D, P_NX, P_END, P_END, P_END};
`endif
      default: ;
    endcase
    return p[k];
  endfunction
  function automatic ctl_t expw(input ph_t p, input logic mr, input logic z, input logic ill);
    ctl_t c;
    c = '0;
    case (p)
      P_F:        begin c.memread = 1; c.srcb = 2'b01; c.irwrite = mr; c.pcen = mr; end
      P_D:        begin c.srcb = 2'b11; c.ill = ill; end
      P_MA, P_AX: begin c.srca = 1; c.srcb = 2'b10; end
      P_MR:       begin c.iord = 1; c.memread = 1; end
      P_MW:       begin c.iord = 1; c.memwrite = 1; end
      P_LWB:      begin c.memtoreg = 1; c.regwrite = 1; end
      P_RX:       begin c.srca = 1; c.aluop = 2'b10; end
      P_RWB:      begin c.regdst = 1; c.regwrite = 1; end
      P_BX, P_NX: begin c.srca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pcen = (p == P_BX) ? z : ~z; end
      P_AWB:      c.regwrite = 1;
      P_JX:       begin c.pcsrc = 2'b10; c.pcen = 1; end
      default: ;
    endcase
    return c;
  endfunction
  function automatic logic [31:0] actual();
    return {12'd0, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
            ALUSrcB, ALUOp, PCSrc, PCEn, Illegal, RetiredCnt};
  endfunction
  function automatic logic [31:0] expect_of(input ctl_t c);
    return {12'd0, c, CW'(ret % (1 << CW))};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic run(input logic [5:0] op, input int fw, input int mw, input int zsel, output int cyc);
    int k, w, nw;
    ph_t p;
    logic mr, z;
    cyc = 0; k = 0; w = 0;
    while (nth(op, k) != P_END) begin
      p = nth(op, k);
      nw = (p == P_F) ? fw : (p == P_MR || p == P_MW) ? mw : -1;
      mr = (nw < 0) ? 1'($urandom) : (w >= nw);
      z = (zsel < 0) ? 1'($urandom) : zsel[0];
      Opcode = (p == P_D) ? op : 6'($urandom);
      MemReady = mr;
      Zero = z;
      @(negedge clk);
      chk(p.name(), actual(), expect_of(expw(p, mr, z, !legal(op))));
      @(posedge clk); #1;
      cyc++;
      if (nw < 0 || mr) begin
        if (nth(op, k + 1) == P_END && legal(op)) ret++;
        k++; w = 0;
      end else w++;
    end
  endtask
  initial begin
    vec_t tv [10];
    logic [5:0] ops [8];
    ctl_t c;
    int cyc;
    tv = '{'{LW, 0, 0, 0, 5}, '{SW, 0, 3, 1, 7}, '{RT, 0, 0, 0, 4}, '{BEQ, 0, 0, 1, 3},
           '{BEQ, 0, 0, 0, 3}, '{ADDI, 2, 0, 0, 6}, '{JMP, 0, 0, 1, 3}, '{BAD, 0, 0, 0, 2},
           '{BNE, 0, 0, 0, BNE_CYC}, '{LW, 1, 2, 1, 8}};
    ops = '{LW, SW, RT, BEQ, ADDI, JMP, BNE, BAD};
    MemReady = 1;
    #3 chk("reset_idle", actual(), 32'd0);
    @(negedge clk); MemReady = 0; #3 rst_n = 1;
    #1 c = '0; c.memread = 1; c.srcb = 2'b01;
    chk("release_fetch", actual(), expect_of(c));
    @(posedge clk); #1;
    Opcode = SW; MemReady = 1;
    repeat (3) begin @(posedge clk); #1; end
    MemReady = 0;
    @(negedge clk);
    c = '0; c.iord = 1; c.memwrite = 1;
    chk("memwr_before_reset", actual(), expect_of(c));
    #2 rst_n = 0; ret = 0;
    #1 chk("reset_mid_memwr", actual(), 32'd0);
    @(negedge clk); #3 rst_n = 1;
    #1 c = '0; c.memread = 1; c.srcb = 2'b01;
    chk("fetch_after_reset", actual(), expect_of(c));
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      run(tv[i].op, tv[i].fw, tv[i].mw, tv[i].z, cyc);
      chk($sformatf("cycles_vec%0d", i), cyc, tv[i].cyc);
    end
    for (int i = 0; i < 17; i++) run(JMP, 0, 0, -1, cyc);
    for (int i = 0; i < 150; i++) begin
      int s;
      logic [5:0] op;
      s = $urandom_range(0, 8);
      op = (s == 8) ? 6'($urandom) : ops[s];
      run(op, $urandom_range(0, 2), $urandom_range(0, 3), -1, cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_main_control.md
Name: mips_multicycle_main_control

Overview:
Main control FSM for the multicycle MIPS datapath. It is the producer side of the ALUOp interface: it drives ALUOp to the ALU control decoder, which resolves ALUOp and funct into the 3-bit ALU operation. It sequences fetch, decode, execute, memory and writeback per opcode, waits on a memory ready handshake, and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
Opcode  in  6  instr[31:26] from instruction register
Zero  in  1  ALU zero flag
MemReady  in  1  memory access completes this cycle
IorD  out  1  memory address select (0=PC, 1=ALUOut)
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
RegDst  out  1  write register select (0=rt, 1=rd)
MemtoReg  out  1  writeback select (0=ALUOut, 1=MDR)
RegWrite  out  1  register file write
ALUSrcA  out  1  ALU A select (0=PC, 1=rs)
ALUSrcB  out  2  ALU B select (00=rt, 01=4, 10=signext, 11=signext<<2)
ALUOp  out  2  to ALU control (00=add, 01=sub, 10=funct)
PCSrc  out  2  next-PC select (00=ALU, 01=ALUOut, 10=jump)
PCEn  out  1  PC load = PCWrite | (Branch & Zero)
Illegal  out  1  one-cycle pulse on unsupported opcode
RetiredCnt  out  CNT_W  retired instructions

Behaviour:
- Reset is asynchronous and active-low; rst_n low forces state=FETCH, RetiredCnt=0, OpReg=0 and every output 0, including the FETCH strobes.
- State register is 4 bits. Outputs are a Moore decode of the state, except MemReady gating where noted. Any output not listed for a state is 0.
- ALUOp is never 11, because the decoder's don't-care matching would make that value ambiguous.
- FETCH: MemRead=1, ALUSrcB=01, ALUOp=00.
  - IRWrite and PCWrite (PCEn) are asserted only when MemReady=1.
  - Stays in FETCH while MemReady=0; MemReady=1 -> DECODE.
- DECODE: ALUSrcB=11, ALUOp=00 (branch target precompute). OpReg<=Opcode. Next state by Opcode:
  - 100011 lw or 101011 sw -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - other -> FETCH with Illegal=1 for this cycle; not counted as retired.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. OpReg=lw -> MEMRD, else MEMWR.
- MEMRD: IorD=1, MemRead=1. Holds until MemReady=1 -> MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1. Holds until MemReady=1 -> FETCH.
- RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RTYPEWB.
- RTYPEWB: RegDst=1, RegWrite=1 -> FETCH.
- BEQEX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
- ADDIWB: RegWrite=1 -> FETCH.
- JEX: PCSrc=10, PCWrite=1 -> FETCH.
- Cycle counts: lw 5, sw 4, R 4, addi 4, beq 3, j 3, plus one extra cycle per cycle MemReady=0 in a waiting state.
- RetiredCnt increments on every transition into FETCH except from DECODE. It wraps from all-ones to 0.
- Unused state encodings -> FETCH next cycle, outputs 0.
- Reset mid-instruction abandons the instruction with no further write strobes. MemWrite drops asynchronously.

Optional Feature:
MAIN_CTRL_BNE_EN
- Defined: opcode 000101 in DECODE -> BNEEX. BNEEX has ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCEn=~Zero, then -> FETCH. bne retires normally.
- Undefined: 000101 is illegal (Illegal pulse, -> FETCH, not counted).

Test Plan:
- Reset with rst_n=0 mid-MEMWR -> all outputs 0 immediately; after release, state FETCH, MemRead=1, RetiredCnt=0.
- lw (100011), MemReady=1 always -> 5 cycles; MEMWB asserts RegWrite=1, MemtoReg=1, RegDst=0; RetiredCnt=1.
- sw with MemReady low 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, IorD=1, total 7 cycles; no RegWrite.
- R-type then beq: RTYPEEX drives ALUOp=10; BEQEX with Zero=1 gives PCEn=1, PCSrc=01; with Zero=0 gives PCEn=0; ALUOp=01; RetiredCnt=2.
- Opcode 111111 -> Illegal=1 for exactly the DECODE cycle, back to FETCH, RetiredCnt unchanged. Repeat with 000101: with MAIN_CTRL_BNE_EN defined, Zero=0 gives PCEn=1; without it, Illegal=1.
- Preload counter near all-ones with back-to-back j instructions -> RetiredCnt wraps to 0; ALUOp never 11 throughout.
